// File: rtl/connect_pkg.sv
// Shared types and encodings for the Connect Four turn controller.
package connect_pkg;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_GO_REL   = 4'd1,
    ST_BOARD    = 4'd2,
    ST_TURN     = 4'd3,
    ST_KEY_REL  = 4'd4,
    ST_AI_WAIT  = 4'd5,
    ST_LOAD     = 4'd6,
    ST_PIECE    = 4'd7,
    ST_CHECK    = 4'd8,
    ST_OVER     = 4'd9,
    ST_OVER_REL = 4'd10,
    ST_MSG      = 4'd11
  } state_t;

  localparam logic [1:0] DRAW_NONE  = 2'b00;
  localparam logic [1:0] DRAW_BOARD = 2'b01;
  localparam logic [1:0] DRAW_PIECE = 2'b10;
  localparam logic [1:0] DRAW_MSG   = 2'b11;

  localparam logic [1:0] RES_PLAY = 2'b00;
  localparam logic [1:0] RES_RED  = 2'b01;
  localparam logic [1:0] RES_BLUE = 2'b10;
  localparam logic [1:0] RES_DRAW = 2'b11;

  localparam logic PLAYER_RED  = 1'b0;
  localparam logic PLAYER_BLUE = 1'b1;

  // Draw-engine request implied by being in a given state.
  function automatic logic [1:0] draw_code(input state_t s);
    case (s)
      ST_BOARD: draw_code = DRAW_BOARD;
      ST_PIECE: draw_code = DRAW_PIECE;
      ST_MSG:   draw_code = DRAW_MSG;
      default:  draw_code = DRAW_NONE;
    endcase
  endfunction

endpackage

// File: rtl/col_legal.sv
// A column choice is legal when exactly one bit is set and that column is not full.
module col_legal #(
  parameter int COLS = 7
) (
  input  logic [COLS-1:0] col_i,
  input  logic [COLS-1:0] full_i,
  output logic            legal_o
);

  localparam logic [COLS-1:0] ONE = COLS'(1);

  logic one_hot_s;

  assign one_hot_s = (col_i != '0) && ((col_i & (col_i - ONE)) == '0);
  assign legal_o   = one_hot_s && ((col_i & full_i) == '0);

endmodule

// File: rtl/connect_turn_ctrl.sv
// Turn sequencer for a parametrised Connect Four board: start, column entry
// (keyboard or AI), piece load/draw, win check, draw-game detection, end message.
module connect_turn_ctrl
  import connect_pkg::*;
#(
  parameter  int COLS = 7,
  parameter  int ROWS = 6,
  localparam int MW   = $clog2(COLS*ROWS+1)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            key_go,
  input  logic [COLS-1:0] key_col,
  input  logic            key_hold,
  input  logic [1:0]      ai_en,
  input  logic [COLS-1:0] ai_col,
  input  logic            ai_valid,
  input  logic [COLS-1:0] col_full,
  input  logic            draw_done,
  input  logic            chk_done,
  input  logic            chk_win,
  output logic [COLS-1:0] load_col,
  output logic            player,
  output logic [1:0]      draw_req,
  output logic            chk_req,
  output logic            ai_req,
  output logic [1:0]      result,
  output logic [MW-1:0]   moves
);

  localparam logic [MW-1:0] MAX_MOVES = MW'(COLS*ROWS);

  state_t          state_q, state_d;
  logic [COLS-1:0] col_q, col_d;
  logic            player_q, player_d;
  logic [1:0]      result_q, result_d;
  logic [MW-1:0]   moves_q, moves_d;
  logic [COLS-1:0] load_col_q, load_col_d;
  logic [1:0]      draw_req_q, draw_req_d;
  logic            chk_req_q, chk_req_d;
  logic            ai_req_q, ai_req_d;
  logic            key_legal_s, ai_legal_s;

  col_legal #(.COLS(COLS)) u_key_legal (
    .col_i   (key_col),
    .full_i  (col_full),
    .legal_o (key_legal_s)
  );

  col_legal #(.COLS(COLS)) u_ai_legal (
    .col_i   (ai_col),
    .full_i  (col_full),
    .legal_o (ai_legal_s)
  );

  // Next-state and next-output logic; outputs are derived from the next state.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    player_d = player_q;
    result_d = result_q;
    moves_d  = moves_q;
    ai_req_d = 1'b0;
    case (state_q)
      ST_IDLE:     if (key_go) state_d = ST_GO_REL; else state_d = ST_IDLE;
      ST_GO_REL: begin
        if (!key_go) begin
          state_d  = ST_BOARD;
          moves_d  = '0;
          result_d = RES_PLAY;
          player_d = PLAYER_RED;
        end else begin
          state_d = ST_GO_REL;
        end
      end
      ST_BOARD:    if (draw_done) state_d = ST_TURN; else state_d = ST_BOARD;
      ST_TURN: begin
        if (ai_en[player_q]) begin
          ai_req_d = 1'b1;
          state_d  = ST_AI_WAIT;
        end else if (key_hold && key_legal_s) begin
          col_d   = key_col;
          state_d = ST_KEY_REL;
        end else begin
          state_d = ST_TURN;
        end
      end
      ST_KEY_REL:  if (!key_hold) state_d = ST_LOAD; else state_d = ST_KEY_REL;
      // An illegal AI pick goes back through TURN so a fresh request is issued.
      ST_AI_WAIT: begin
        if (ai_valid && ai_legal_s) begin
          col_d   = ai_col;
          state_d = ST_LOAD;
        end else if (ai_valid) begin
          state_d = ST_TURN;
        end else begin
          state_d = ST_AI_WAIT;
        end
      end
      ST_LOAD: begin
        state_d = ST_PIECE;
        if (moves_q != MAX_MOVES) moves_d = moves_q + MW'(1); else moves_d = moves_q;
      end
      ST_PIECE:    if (draw_done) state_d = ST_CHECK; else state_d = ST_PIECE;
      // A win on the last free cell beats the draw verdict.
      ST_CHECK: begin
        if (chk_done && chk_win) begin
          result_d = (player_q == PLAYER_BLUE) ? RES_BLUE : RES_RED;
          state_d  = ST_OVER;
        end else if (chk_done && (moves_q == MAX_MOVES)) begin
          result_d = RES_DRAW;
          state_d  = ST_OVER;
        end else if (chk_done) begin
          player_d = ~player_q;
          state_d  = ST_TURN;
        end else begin
          state_d = ST_CHECK;
        end
      end
      ST_OVER:     if (key_go) state_d = ST_OVER_REL; else state_d = ST_OVER;
      ST_OVER_REL: if (!key_go) state_d = ST_MSG; else state_d = ST_OVER_REL;
      ST_MSG:      if (draw_done) state_d = ST_IDLE; else state_d = ST_MSG;
      default:     state_d = ST_IDLE;
    endcase

    load_col_d = (state_d == ST_LOAD) ? col_d : '0;
    draw_req_d = draw_code(state_d);
    chk_req_d  = (state_d == ST_CHECK) && (state_q != ST_CHECK);
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      col_q      <= '0;
      player_q   <= PLAYER_RED;
      result_q   <= RES_PLAY;
      moves_q    <= '0;
      load_col_q <= '0;
      draw_req_q <= DRAW_NONE;
      chk_req_q  <= 1'b0;
      ai_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      player_q   <= player_d;
      result_q   <= result_d;
      moves_q    <= moves_d;
      load_col_q <= load_col_d;
      draw_req_q <= draw_req_d;
      chk_req_q  <= chk_req_d;
      ai_req_q   <= ai_req_d;
    end
  end

  assign load_col = load_col_q;
  assign player   = player_q;
  assign draw_req = draw_req_q;
  assign chk_req  = chk_req_q;
  assign ai_req   = ai_req_q;
  assign result   = result_q;
  assign moves    = moves_q;

endmodule

// File: tb/tb_connect_turn_ctrl.sv
// Self-checking bench: a 7x6 instance for the game flow and a 4x2 instance for board-full handling.
module tb_connect_turn_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0, resetn_s = 1'b0;
  logic       key_go = 1'b0, key_hold = 1'b0, ai_valid = 1'b0;
  logic       draw_done = 1'b0, chk_done = 1'b0, chk_win = 1'b0;
  logic [1:0] ai_en = 2'b00;
  logic [6:0] key_col = 7'd0, ai_col = 7'd0, col_full = 7'd0;
  logic [6:0] load_col;
  logic       player, chk_req, ai_req;
  logic [1:0] draw_req, result;
  logic [5:0] moves;
  logic [3:0] key_col_s = 4'd0, ai_col_s = 4'd0, col_full_s = 4'd0;
  logic [3:0] load_col_s;
  logic       player_s, chk_req_s, ai_req_s;
  logic [1:0] draw_req_s, result_s;
  logic [3:0] moves_s;

  int n_cmp = 0;
  int n_err = 0;
  logic [6:0] exp_col_q[$];
  logic [3:0] exp_col_s_q[$];
  logic [1:0] exp_res_q[$];

  connect_turn_ctrl #(.COLS(7), .ROWS(6)) dut (
    .clk(clk), .resetn(resetn), .key_go(key_go), .key_col(key_col), .key_hold(key_hold),
    .ai_en(ai_en), .ai_col(ai_col), .ai_valid(ai_valid), .col_full(col_full),
    .draw_done(draw_done), .chk_done(chk_done), .chk_win(chk_win),
    .load_col(load_col), .player(player), .draw_req(draw_req), .chk_req(chk_req),
    .ai_req(ai_req), .result(result), .moves(moves)
  );

  connect_turn_ctrl #(.COLS(4), .ROWS(2)) dut_s (
    .clk(clk), .resetn(resetn_s), .key_go(key_go), .key_col(key_col_s), .key_hold(key_hold),
    .ai_en(ai_en), .ai_col(ai_col_s), .ai_valid(ai_valid), .col_full(col_full_s),
    .draw_done(draw_done), .chk_done(chk_done), .chk_win(chk_win),
    .load_col(load_col_s), .player(player_s), .draw_req(draw_req_s), .chk_req(chk_req_s),
    .ai_req(ai_req_s), .result(result_s), .moves(moves_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the load strobe, then walks piece draw and win check.
  task automatic finish_move7(input logic win);
    logic [6:0] e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      tick();
      ai_valid = 1'b0;
      if (load_col != 7'd0) seen = 1'b1;
    end
    e = exp_col_q.pop_front();
    n_cmp++; if (!seen || load_col !== e) begin n_err++; $display("FAIL load_col: got %b want %b", load_col, e); end
    tick();
    n_cmp++; if (load_col !== 7'd0) begin n_err++; $display("FAIL load_pulse: got %b want 0", load_col); end
    n_cmp++; if (draw_req !== 2'b10) begin n_err++; $display("FAIL draw_piece: got %b want 10", draw_req); end
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0;
    n_cmp++; if (chk_req !== 1'b1) begin n_err++; $display("FAIL chk_req: got %b want 1", chk_req); end
    chk_done = 1'b1; chk_win = win;
    tick();
    chk_done = 1'b0; chk_win = 1'b0;
  endtask

  task automatic move7(input logic [6:0] col, input logic win);
    key_col = col; key_hold = 1'b1;
    exp_col_q.push_back(col);
    tick();
    key_hold = 1'b0;
    finish_move7(win);
  endtask

  task automatic move_s(input logic [3:0] col, input logic win);
    logic [3:0] e;
    key_col_s = col; key_hold = 1'b1;
    exp_col_s_q.push_back(col);
    tick();
    key_hold = 1'b0;
    tick();
    e = exp_col_s_q.pop_front();
    n_cmp++; if (load_col_s !== e) begin n_err++; $display("FAIL load_col_s: got %b want %b", load_col_s, e); end
    tick();
    draw_done = 1'b1;
    tick();
    draw_done = 1'b0; chk_done = 1'b1; chk_win = win;
    tick();
    chk_done = 1'b0; chk_win = 1'b0;
  endtask

  task automatic start_game();
    key_go = 1'b1; tick();
    key_go = 1'b0; tick();
  endtask

  task automatic test_reset();
    tick(); tick(); tick();
    n_cmp++; if ({load_col, player, draw_req, chk_req, ai_req, result, moves} !== 20'd0) begin
      n_err++; $display("FAIL reset: got %h want 0", {load_col, player, draw_req, chk_req, ai_req, result, moves}); end
    resetn = 1'b1;
  endtask

  task automatic test_start();
    start_game();
    n_cmp++; if (draw_req !== 2'b01) begin n_err++; $display("FAIL draw_board: got %b want 01", draw_req); end
    n_cmp++; if ({player, moves, result} !== 9'd0) begin n_err++; $display("FAIL start_clear: got %h want 0", {player, moves, result}); end
    for (int i = 0; i < 10; i++) tick();
    n_cmp++; if (draw_req !== 2'b01) begin n_err++; $display("FAIL board_level: got %b want 01", draw_req); end
    draw_done = 1'b1; tick(); draw_done = 1'b0;
    n_cmp++; if (draw_req !== 2'b00) begin n_err++; $display("FAIL board_drop: got %b want 00", draw_req); end
  endtask

  task automatic test_human();
    move7(7'b0000100, 1'b0);
    n_cmp++; if (player !== 1'b1) begin n_err++; $display("FAIL human_player: got %b want 1", player); end
    n_cmp++; if (moves !== 6'd1) begin n_err++; $display("FAIL human_moves: got %0d want 1", moves); end
  endtask

  task automatic test_illegal();
    for (int k = 0; k < 2; k++) begin
      key_col  = (k == 0) ? 7'b0001100 : 7'b0000100;
      col_full = (k == 0) ? 7'b0000000 : 7'b0000100;
      key_hold = 1'b1; tick(); tick();
      key_hold = 1'b0; tick(); tick();
      n_cmp++; if (load_col !== 7'd0 || draw_req !== 2'b00) begin
        n_err++; $display("FAIL illegal_%0d: got load %b draw %b want 0/00", k, load_col, draw_req); end
    end
    col_full = 7'd0;
    move7(7'b0000010, 1'b0);
    n_cmp++; if (player !== 1'b0 || moves !== 6'd2) begin
      n_err++; $display("FAIL after_illegal: got p%b m%0d want p0 m2", player, moves); end
  endtask

  task automatic test_ai();
    bit seen;
    ai_en = 2'b10;
    move7(7'b0000001, 1'b0);
    tick();
    n_cmp++; if (ai_req !== 1'b1) begin n_err++; $display("FAIL ai_req: got %b want 1", ai_req); end
    tick();
    n_cmp++; if (ai_req !== 1'b0) begin n_err++; $display("FAIL ai_req_pulse: got %b want 0", ai_req); end
    ai_col = 7'b0001000; col_full = 7'b0001000; ai_valid = 1'b1;
    tick();
    ai_valid = 1'b0;
    n_cmp++; if (load_col !== 7'd0) begin n_err++; $display("FAIL ai_full: got %b want 0", load_col); end
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin tick(); if (ai_req === 1'b1) seen = 1'b1; end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL ai_reissue: got no ai_req want ai_req"); end
    ai_col = 7'b0100000; ai_valid = 1'b1;
    exp_col_q.push_back(7'b0100000);
    finish_move7(1'b0);
    col_full = 7'd0; ai_en = 2'b00;
    n_cmp++; if (player !== 1'b0 || moves !== 6'd4) begin
      n_err++; $display("FAIL after_ai: got p%b m%0d want p0 m4", player, moves); end
  endtask

  task automatic test_win();
    logic [1:0] e;
    exp_res_q.push_back(2'b01);
    move7(7'b1000000, 1'b1);
    e = exp_res_q.pop_front();
    n_cmp++; if (result !== e || draw_req !== 2'b00) begin
      n_err++; $display("FAIL red_win: got res %b draw %b want %b/00", result, draw_req, e); end
    key_go = 1'b1; tick(); tick();
    n_cmp++; if (draw_req !== 2'b00) begin n_err++; $display("FAIL over_hold: got %b want 00", draw_req); end
    key_go = 1'b0; tick();
    n_cmp++; if (draw_req !== 2'b11) begin n_err++; $display("FAIL draw_msg: got %b want 11", draw_req); end
    draw_done = 1'b1; tick(); draw_done = 1'b0;
    n_cmp++; if (draw_req !== 2'b00 || result !== 2'b01) begin
      n_err++; $display("FAIL msg_done: got draw %b res %b want 00/01", draw_req, result); end
  endtask

  task automatic test_restart();
    start_game();
    n_cmp++; if (result !== 2'b00 || moves !== 6'd0 || draw_req !== 2'b01) begin
      n_err++; $display("FAIL restart: got res %b m%0d draw %b want 00/0/01", result, moves, draw_req); end
    resetn = 1'b0; tick();
    n_cmp++; if (draw_req !== 2'b00) begin n_err++; $display("FAIL mid_reset: got %b want 00", draw_req); end
  endtask

  task automatic test_draw(input logic last_win, input logic [1:0] want);
    logic [1:0] e;
    logic [3:0] cols [8];
    cols = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
    resetn_s = 1'b0; tick(); resetn_s = 1'b1;
    n_cmp++; if (result_s !== 2'b00) begin n_err++; $display("FAIL small_reset: got %b want 00", result_s); end
    start_game();
    draw_done = 1'b1; tick(); draw_done = 1'b0;
    for (int i = 0; i < 7; i++) move_s(cols[i], 1'b0);
    n_cmp++; if (result_s !== 2'b00 || player_s !== 1'b1 || moves_s !== 4'd7) begin
      n_err++; $display("FAIL seven_moves: got res %b p%b m%0d want 00/1/7", result_s, player_s, moves_s); end
    exp_res_q.push_back(want);
    move_s(cols[7], last_win);
    e = exp_res_q.pop_front();
    n_cmp++; if (result_s !== e || moves_s !== 4'd8) begin
      n_err++; $display("FAIL board_full: got res %b m%0d want %b/8", result_s, moves_s, e); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_human();
    test_illegal();
    test_ai();
    test_win();
    test_restart();
    test_draw(1'b0, 2'b11);
    test_draw(1'b1, 2'b10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/connect_turn_ctrl.md
# connect_turn_ctrl

Parametrised turn controller for the Connect Four game: sequences board draw, per-turn column entry (keyboard or AI), piece load, piece draw, win check, draw-game detection and end-of-game message. Sits between keyboard/AI column sources and the board-RAM, VGA draw engine and win checker. Unlike the fixed 7×6 controller, it is sized by parameters, supports selectable human/human or human/AI play per player, rejects full or illegal columns, and uses req/done handshakes instead of fixed cycle counts.

## Interface
- COLS, 7, board columns (2..16)
- ROWS, 6, board rows (2..16)
- MW, $clog2(COLS*ROWS+1), move-counter width (derived, localparam)
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- key_go  in  1  spacebar level
- key_col  in  COLS  one-hot column from keyboard
- key_hold  in  1  column key held (level)
- ai_en  in  2  bit p=1: player p is AI (p0 red, p1 blue)
- ai_col  in  COLS  one-hot AI column
- ai_valid  in  1  AI column ready (pulse)
- col_full  in  COLS  column full status from board RAM
- draw_done  in  1  draw-engine completion pulse
- chk_done  in  1  win-check completion pulse
- chk_win  in  1  win flag, valid with chk_done
- load_col  out  COLS  one-hot column write strobe (1 cycle)
- player  out  1  current player, 0 red, 1 blue
- draw_req  out  2  00 none, 01 board, 10 piece, 11 message (level until draw_done)
- chk_req  out  1  win-check start (1 cycle)
- ai_req  out  1  AI move request (1 cycle)
- result  out  2  00 playing, 01 red win, 10 blue win, 11 draw
- moves  out  MW  pieces placed

## Operation
- States: IDLE, GO_REL, BOARD, TURN, KEY_REL, AI_WAIT, LOAD, PIECE, CHECK, OVER, OVER_REL, MSG.
- IDLE: key_go=1 → GO_REL; GO_REL: key_go=0 → BOARD (clears moves, result, player=0).
- BOARD: draw_req=01; draw_done → TURN.
- TURN: if ai_en[player]: pulse ai_req, → AI_WAIT. Else key_hold=1 with key_col legal → latch col, KEY_REL; illegal → stay.
- Legal column: key_col/ai_col exactly one-hot and (col & col_full)==0. Illegal AI column → re-issue ai_req next cycle (back to TURN).
- KEY_REL: key_hold=0 → LOAD. AI_WAIT: ai_valid with legal ai_col → latch, LOAD.
- LOAD: load_col=latched col for 1 cycle, moves+1 → PIECE.
- PIECE: draw_req=10; draw_done → CHECK. chk_req pulses on entry cycle.
- CHECK: chk_done&chk_win → result=01/10 per player, OVER; chk_done&!chk_win&moves==COLS*ROWS → result=11, OVER; chk_done otherwise → toggle player, TURN.
- OVER: key_go=1 → OVER_REL; key_go=0 → MSG. MSG: draw_req=11; draw_done → IDLE, result held until next BOARD.
- draw_done/chk_done/ai_valid outside their waiting state ignored.

## Timing
- Reset (resetn=0 at clk edge): state IDLE, load_col=0, player=0, draw_req=00, chk_req=0, ai_req=0, result=00, moves=0. Reset mid-game abandons all handshakes.
- All outputs registered (Moore, from next-state); changes appear the cycle after the triggering edge.
- Minimum human move: KEY_REL→LOAD 1 cycle, LOAD→PIECE 1 cycle, then draw latency, then check latency.
- draw_done same cycle as draw_req rise accepted; chk_done may arrive cycle after chk_req.
- Simultaneous win and full board → win takes priority.
- moves saturates at COLS*ROWS; never wraps.

## Structure
- Package connect_pkg: state enum, draw_req encodings (DRAW_NONE/BOARD/PIECE/MSG), result encodings (RES_PLAY/RED/BLUE/DRAW), player constants.
- One sub-module: col_legal (one-hot check + col_full mask, combinational, COLS-parametrised), instanced twice (key, AI).

## Test plan
- Start: key_go 1→0, draw_done after 10 cycles → draw_req 01 then TURN, player=0, moves=0.
- Human move: key_col=0000100, key_hold pulse, release → load_col=0000100 one cycle, draw_req=10, chk_req pulse; chk_done, no win → player=1.
- Illegal: key_col=0001100 or col_full[2]=1 with key_col=0000100 → no load_col, stays TURN.
- AI: ai_en=2'b10, blue turn → ai_req pulse; ai_valid with full column → ai_req reissued; legal col → load.
- Win: chk_win on red move → result=01, OVER; key_go press/release → draw_req=11; draw_done → IDLE.
- Draw: COLS=4, ROWS=2, 8 moves no win → result=11; same move with chk_win → result=win.
